// File: rtl/reg_bank_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_wr_arbiter
// Purpose  : Round-robin arbiter that multiplexes N_REQ writers onto one
//            registered register-bank write port, with stall and $zero discard.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_wr_arbiter #(
    parameter int N_REQ        = 4,
    parameter int WIDTH        = 32,
    parameter int ADDR_W       = 5,
    parameter int ZERO_DISCARD = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      stall,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*WIDTH-1:0]    req_data,
    output logic [N_REQ-1:0]          gnt,
    output logic [$clog2(N_REQ)-1:0]  gnt_idx,
    output logic                      we,
    output logic [ADDR_W-1:0]         waddr,
    output logic [WIDTH-1:0]          wdata
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_REQ - 1);

    logic [N_REQ-1:0]  r_gnt;
    logic [IDX_W-1:0]  r_gnt_idx;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [WIDTH-1:0]  r_wdata;
    logic [IDX_W-1:0]  r_ptr;

    logic [N_REQ-1:0]  w_elig;
    logic              w_found;
    logic [IDX_W-1:0]  w_win;
    logic [31:0]       w_j;
    logic [N_REQ-1:0]  w_onehot;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_discard;

    // Last cycle's winner is masked so a req held through its grant is not re-served.
    assign w_elig = req & ~r_gnt;

    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_j        = '0;
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_j = (32'(r_ptr) + k) % N_REQ;
            if (!w_found && w_elig[w_j]) begin
                w_found    = 1'b1;
                w_win      = IDX_W'(w_j);
                w_sel_addr = req_addr[w_j*ADDR_W +: ADDR_W];
                w_sel_data = req_data[w_j*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        w_onehot        = '0;
        w_onehot[w_win] = 1'b1;
    end

    assign w_discard = (ZERO_DISCARD != 0) && (w_sel_addr == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt     <= '0;
            r_gnt_idx <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_ptr     <= '0;
        end else if (!stall && w_found) begin
            r_gnt     <= w_onehot;
            r_gnt_idx <= w_win;
            r_we      <= !w_discard;
            r_waddr   <= w_sel_addr;
            r_wdata   <= w_sel_data;
            r_ptr     <= (w_win == c_last_idx) ? '0 : w_win + 1'b1;
        end else begin
            r_gnt     <= '0;
            r_we      <= 1'b0;
        end
    end

    assign gnt     = r_gnt;
    assign gnt_idx = r_gnt_idx;
    assign we      = r_we;
    assign waddr   = r_waddr;
    assign wdata   = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_bank_wr_arbiter
// Purpose  : Scoreboard bench for reg_bank_wr_arbiter (two zero-discard builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_bank_wr_arbiter;

    logic        clk;
    logic        rst;
    logic        stall;
    logic [3:0]  req;
    logic [19:0] req_addr;
    logic [127:0] req_data;

    logic [3:0]  gnt,  gnt0;
    logic [1:0]  gnt_idx, gnt_idx0;
    logic        we,   we0;
    logic [4:0]  waddr, waddr0;
    logic [31:0] wdata, wdata0;

    reg_bank_wr_arbiter #(.N_REQ(4), .WIDTH(32), .ADDR_W(5), .ZERO_DISCARD(1)) dut (
        .clk(clk), .rst(rst), .stall(stall), .req(req), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt), .gnt_idx(gnt_idx), .we(we),
        .waddr(waddr), .wdata(wdata)
    );

    reg_bank_wr_arbiter #(.N_REQ(4), .WIDTH(32), .ADDR_W(5), .ZERO_DISCARD(0)) dut0 (
        .clk(clk), .rst(rst), .stall(stall), .req(req), .req_addr(req_addr),
        .req_data(req_data), .gnt(gnt0), .gnt_idx(gnt_idx0), .we(we0),
        .waddr(waddr0), .wdata(wdata0)
    );

    typedef struct packed {
        logic [3:0]  gnt;
        logic [1:0]  idx;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we0;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (time=%0t)", $time);
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
        req_addr[i*5 +: 5]   = a;
        req_data[i*32 +: 32] = d;
    endtask

    // Expected response of a grant to requester i carrying address a / data d.
    task automatic push_grant(input int i, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.gnt   = 4'b0001 << i;
        e.idx   = 2'(i);
        e.we    = (a != 5'd0);
        e.waddr = a;
        e.wdata = d;
        e.we0   = 1'b1;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every grant the DUT presents must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && (gnt !== 4'b0000 || we !== 1'b0)) begin
            exp_t e;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_grant: gnt=%b we=%b waddr=%0d with no expected grant",
                         gnt, we, waddr);
            end else begin
                e = q.pop_front();
                if (gnt !== e.gnt || gnt_idx !== e.idx || we !== e.we ||
                    waddr !== e.waddr || wdata !== e.wdata ||
                    gnt0 !== e.gnt || we0 !== e.we0 || waddr0 !== e.waddr) begin
                    n_fail++;
                    $display("FAIL grant: got gnt=%b idx=%0d we=%b waddr=%0d wdata=%h we0=%b expected gnt=%b idx=%0d we=%b waddr=%0d wdata=%h we0=%b",
                             gnt, gnt_idx, we, waddr, wdata, we0,
                             e.gnt, e.idx, e.we, e.waddr, e.wdata, e.we0);
                end
            end
        end
    end

    initial begin
        rst   = 1'b0;
        stall = 1'b0;
        req   = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, 5'(10 + i), 32'hA000_0000 + 32'(i));

        // Reset held with requests pending and clock running
        step(); step(); step();
        check("reset_gnt",   32'(gnt),     32'h0);
        check("reset_we",    32'(we),      32'h0);
        check("reset_waddr", 32'(waddr),   32'h0);
        check("reset_wdata", wdata,        32'h0);
        check("reset_idx",   32'(gnt_idx), 32'h0);

        // Release: requester 0 wins at the first posedge
        push_grant(0, 5'd10, 32'hA000_0000);
        rst = 1'b1;
        step();
        req = 4'b0000;
        step();

        // Single requester (ptr=1)
        set_req(2, 5'd7, 32'hDEADBEEF);
        req = 4'b0100;
        push_grant(2, 5'd7, 32'hDEADBEEF);
        step();
        req = 4'b0000;
        step();
        check("single_we_off", 32'(we), 32'h0);

        // Requester 3 alone brings ptr to 0, then all four request continuously
        req = 4'b1000;
        push_grant(3, 5'd13, 32'hA000_0003);
        step();
        req = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            push_grant(0, 5'd10, 32'hA000_0000);
            push_grant(1, 5'd11, 32'hA000_0001);
            push_grant(2, 5'd7,  32'hDEADBEEF);
            push_grant(3, 5'd13, 32'hA000_0003);
        end
        for (int c = 0; c < 8; c++) step();
        req = 4'b0000;
        step();

        // Stall with two pending requesters (ptr=0)
        req   = 4'b0011;
        stall = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            check("stall_gnt", 32'(gnt), 32'h0);
            check("stall_we",  32'(we),  32'h0);
        end
        stall = 1'b0;
        push_grant(0, 5'd10, 32'hA000_0000);
        step();
        req = 4'b0010;
        push_grant(1, 5'd11, 32'hA000_0001);
        step();
        req = 4'b0000;
        step();

        // Write to $zero (ptr=2): consumed, we suppressed only where discard is on
        set_req(1, 5'd0, 32'h0000_1234);
        req = 4'b0010;
        push_grant(1, 5'd0, 32'h0000_1234);
        step();
        req = 4'b0000;
        step();
        set_req(1, 5'd11, 32'hA000_0001);

        // Request held one cycle past its grant is served only once (ptr=2)
        req = 4'b0100;
        push_grant(2, 5'd7, 32'hDEADBEEF);
        step();
        step();
        req = 4'b0000;
        step();

        // Reset mid-operation while requester 3 is granted (ptr=3)
        req = 4'b1000;
        step();
        check("midrst_pre_gnt", 32'(gnt), 32'h8);
        rst = 1'b0;
        req = 4'b1010;
        #1;
        check("midrst_gnt", 32'(gnt), 32'h0);
        check("midrst_we",  32'(we),  32'h0);
        step();
        step();
        rst = 1'b1;
        push_grant(1, 5'd11, 32'hA000_0001);
        step();
        req = 4'b1000;
        push_grant(3, 5'd13, 32'hA000_0003);
        step();
        req = 4'b0000;
        step();
        step();
        check("scoreboard_drained", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_bank_wr_arbiter.md
Name: reg_bank_wr_arbiter

Overview:
- Round-robin arbiter sharing one write port of a D-flip-flop register bank (register file or pipeline-register group) between N_REQ requesters, e.g. WB stage, mul/div unit and CP0.
- Picks one pending requester per cycle and registers its address and data onto a single write bus.
- The write bus (we, waddr, wdata) drives the bank's enable and D inputs directly.
- Provides stall gating and optional discard of writes to address 0 (MIPS $zero).

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 32, write data width.
- ADDR_W, 5, write address width.
- ZERO_DISCARD, 1, when 1 a granted write to address 0 is consumed but we stays 0.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous reset, active-low (0 = reset).
- stall  input  1  1 = no new grant this cycle.
- req  input  N_REQ  per-requester write request.
- req_addr  input  N_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_data  input  N_REQ*WIDTH  flattened data; requester i at bits [i*WIDTH +: WIDTH].
- gnt  output  N_REQ  registered one-hot grant, high for exactly one cycle per served request.
- gnt_idx  output  $clog2(N_REQ)  index of the last granted requester.
- we  output  1  registered bank write enable.
- waddr  output  ADDR_W  registered bank write address.
- wdata  output  WIDTH  registered bank write data.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately regardless of clk):
  - gnt=0, we=0, waddr=0, wdata=0, gnt_idx=0, round-robin pointer ptr=0.
- Reset release:
  - First arbitration happens at the first posedge with rst=1.
- Eligibility:
  - eligible[i] = req[i] & ~gnt[i].
  - A requester granted in the previous cycle is masked for one cycle, so holding req one extra cycle is never double-served.
- Selection:
  - Winner w = first eligible index scanning ptr, ptr+1, ..., N_REQ-1, 0, ..., ptr-1 (modulo wrap).
- Posedge with stall=0 and any eligible requester:
  - gnt <= onehot(w), gnt_idx <= w.
  - waddr <= req_addr[w], wdata <= req_data[w].
  - we <= 1, except we <= 0 when ZERO_DISCARD=1 and req_addr[w]==0.
  - ptr <= (w+1) mod N_REQ.
- Posedge with stall=1, or no eligible requester:
  - gnt <= 0, we <= 0.
  - waddr, wdata, gnt_idx and ptr hold their values.
- Latency:
  - A request sampled at posedge k appears on gnt/we/waddr/wdata after posedge k.
  - The bank captures it at posedge k+1.
- Requester handshake:
  - Hold req, addr and data stable until gnt[i] is seen high.
  - Deassert req, or present the next transfer, in the cycle gnt[i] is high.
  - The new transfer is eligible from the following cycle.
- Fairness:
  - With all N_REQ requesting continuously, each requester is granted exactly once every N_REQ cycles.
  - No requester waits more than N_REQ-1 grants.
- Simultaneous events:
  - stall overrides any request.
  - A request arriving in the same cycle stall drops is arbitrated at that same posedge.
- Reset mid-operation:
  - An in-flight grant is cancelled (we forced 0 immediately).
  - ptr returns to 0.
  - Pending requests are re-arbitrated after release.
- gnt is always one-hot or zero; we=1 implies gnt!=0.

Test Plan:
- Reset: rst=0 with req=4'b1111 and clk running -> gnt=0, we=0, waddr=0, wdata=0. Release rst -> at the first posedge gnt=4'b0001, waddr=req_addr[0].
- Single requester: req[2]=1, addr=5'd7, data=32'hDEADBEEF for one cycle -> next cycle gnt=4'b0100, we=1, waddr=7, wdata=DEADBEEF. Following cycle we=0.
- Fairness and wrap: req=4'b1111 held for 8 cycles, each requester keeping req through its gnt cycle -> gnt sequence 0001,0010,0100,1000,0001,0010,0100,1000. No requester granted twice in a row.
- Stall: req=4'b0011 pending and stall=1 for 3 cycles -> gnt=0, we=0, ptr unchanged. Drop stall -> gnt=0001, then 0010.
- Zero discard: req[1]=1, addr=0, data=32'h1234 with ZERO_DISCARD=1 -> gnt=4'b0010, we=0. Same stimulus with ZERO_DISCARD=0 -> we=1, waddr=0.
- Reset mid-operation: rst=0 asserted between posedges while gnt=4'b1000 -> we and gnt drop to 0 before the next edge. After release with req=4'b1010 -> gnt=4'b0010 first, because ptr is back at 0.
